// File: rtl/id_stage_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer, valid/ready handshake,
// synchronous flush to a NOP bubble and a saturating stall counter.
module id_stage_reg #(
  parameter int                   PC_W      = 64,
  parameter int                   INSTR_W   = 32,
  parameter int                   SB_W      = 4,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000013,
  parameter int                   CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [SB_W-1:0]    in_sb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [SB_W-1:0]    out_sb,
  input  logic               flush,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [SB_W-1:0]    skid_sb;
  logic               in_fire;
  logic               out_fire;

  // Handshakes use only registered ready/valid, so no input reaches an output.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      out_pc     <= '0;
      out_instr  <= NOP_INSTR;
      out_sb     <= '0;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
      skid_sb    <= '0;
      stall_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (flush) begin
        state      <= EMPTY;
        out_valid  <= 1'b0;
        in_ready   <= 1'b1;
        out_pc     <= '0;
        out_instr  <= NOP_INSTR;
        out_sb     <= '0;
        skid_pc    <= '0;
        skid_instr <= NOP_INSTR;
        skid_sb    <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              state     <= ONE;
              out_valid <= 1'b1;
              out_pc    <= in_pc;
              out_instr <= in_instr;
              out_sb    <= in_sb;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              out_pc    <= in_pc;
              out_instr <= in_instr;
              out_sb    <= in_sb;
            end else if (in_fire) begin
              state      <= TWO;
              in_ready   <= 1'b0;
              skid_pc    <= in_pc;
              skid_instr <= in_instr;
              skid_sb    <= in_sb;
            end else if (out_fire) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              out_pc    <= '0;
              out_instr <= NOP_INSTR;
              out_sb    <= '0;
            end
          end
          TWO: begin
            if (out_fire) begin
              state      <= ONE;
              in_ready   <= 1'b1;
              out_pc     <= skid_pc;
              out_instr  <= skid_instr;
              out_sb     <= skid_sb;
              skid_pc    <= '0;
              skid_instr <= NOP_INSTR;
              skid_sb    <= '0;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_pc    <= '0;
            out_instr <= NOP_INSTR;
            out_sb    <= '0;
          end
        endcase
      end
    end
  end

endmodule
